// File: rtl/mem_arbiter_2port.sv
// Two-port arbiter and sequencer for the shared 128-bit line memory.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on ties instead of fixed port 0 priority.
module mem_arbiter_2port #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_ready,
  output logic              grant,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [TMR_W-1:0]  wdog_q;
  logic              p0_ready_q;
  logic              p1_ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_valid_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              grant_q;
  logic              busy_q;
  logic              err_q;
  logic              win_d;
  logic              any_req;

  assign any_req = p0_valid | p1_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;

  // Tie goes to the port not granted last; a lone requester always wins.
  always_comb begin
    win_d = p1_valid;
    if (p0_valid && p1_valid) win_d = ~rr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_q <= 1'b1;
    else if (state_q == IDLE && any_req) rr_q <= win_d;
  end
`else
  always_comb begin
    win_d = ~p0_valid;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wdog_q        <= '0;
      p0_ready_q    <= 1'b0;
      p1_ready_q    <= 1'b0;
      rdata_q       <= '0;
      mem_valid_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      mem_valid_q <= 1'b0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q       <= ISSUE;
            busy_q        <= 1'b1;
            mem_valid_q   <= 1'b1;
            grant_q       <= win_d;
            mem_write_q   <= win_d ? p1_write : p0_write;
            mem_address_q <= win_d ? p1_address : p0_address;
            mem_wdata_q   <= win_d ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wdog_q  <= TMR_W'(TIMEOUT_CYCLES);
        end
        WAIT: begin
          if (mem_ready) begin
            rdata_q    <= mem_out;
            state_q    <= RESP;
            p0_ready_q <= ~grant_q;
            p1_ready_q <= grant_q;
          end else if (wdog_q == '0) begin
            rdata_q    <= '1;
            err_q      <= 1'b1;
            state_q    <= RESP;
            p0_ready_q <= ~grant_q;
            p1_ready_q <= grant_q;
          end else begin
            wdog_q <= wdog_q - TMR_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign p0_ready    = p0_ready_q;
  assign p1_ready    = p1_ready_q;
  assign rdata       = rdata_q;
  assign mem_valid   = mem_valid_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed bench for mem_arbiter_2port: vector table plus tie, timeout,
// reset and re-request sequences. Honors ARB_ROUND_ROBIN_EN for tie order.
module tb_mem_arbiter_2port;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_valid, p0_write, p0_ready;
  logic [AW-1:0] p0_address;
  logic [DW-1:0] p0_wdata;
  logic          p1_valid, p1_write, p1_ready;
  logic [AW-1:0] p1_address;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] rdata;
  logic          mem_valid, mem_write, mem_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_out;
  logic          grant, busy, err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_arbiter_2port #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TMR_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_write(p0_write),
    .p0_address(p0_address), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_write(p1_write),
    .p1_address(p1_address), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready),
    .rdata(rdata),
    .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_out(mem_out), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .err(err)
  );

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            lat;
    logic [DW-1:0] mout;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int port, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port == 0) begin
      p0_valid = 1'b1; p0_write = wr; p0_address = addr; p0_wdata = wd;
    end else begin
      p1_valid = 1'b1; p1_write = wr; p1_address = addr; p1_wdata = wd;
    end
  endtask

  task automatic drop_req(input int port);
    if (port == 0) p0_valid = 1'b0;
    else p1_valid = 1'b0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (!mem_valid && n < 20) begin
      tick();
      n++;
    end
    chk("issue_seen", 128'(mem_valid), 128'(1));
  endtask

  // Waits for the issue, checks the command, answers after lat cycles.
  task automatic serve(input int port, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int lat, input logic [DW-1:0] mout,
                       input logic [DW-1:0] exp, input bit drop,
                       output int n);
    wait_issue(n);
    chk("grant", 128'(grant), 128'(port));
    chk("busy", 128'(busy), 128'(1));
    chk("mem_address", 128'(mem_address), 128'(addr));
    chk("mem_write", 128'(mem_write), 128'(wr));
    if (wr) chk("mem_wdata", mem_wdata, wd);
    tick();
    chk("mem_valid_pulse", 128'(mem_valid), 128'(0));
    repeat (lat) tick();
    chk("ready_early", 128'({p0_ready, p1_ready}), 128'(0));
    mem_ready = 1'b1;
    mem_out = mout;
    tick();
    mem_ready = 1'b0;
    chk("px_ready", 128'({p1_ready, p0_ready}),
        128'(port == 0 ? 2'b01 : 2'b10));
    chk("rdata", rdata, exp);
    if (drop) drop_req(port);
    tick();
    chk("ready_one_cycle", 128'({p0_ready, p1_ready}), 128'(0));
  endtask

  task automatic do_access(input vec_t v);
    int n;
    set_req(v.port, v.wr, v.addr, v.wd);
    serve(v.port, v.wr, v.addr, v.wd, v.lat, v.mout, v.mout, 1'b1, n);
    chk("issue_latency", 128'(n), 128'(1));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    int exp_p [3];
    logic [DW-1:0] pat;

    vecs[0] = '{0, 1'b0, 32'h40, '0, 10,
                128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[1] = '{1, 1'b1, 32'h80, {8{16'hAAAA}} ^ {4{32'h0000FFFF}},
                2, {8{16'hAAAA}} ^ {4{32'h0000FFFF}}};
    vecs[2] = '{0, 1'b1, 32'h100, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                0, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    vecs[3] = '{1, 1'b0, 32'h1C0, '0, 5,
                128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE};

    reset = 1'b1;
    p0_valid = 0; p0_write = 0; p0_address = '0; p0_wdata = '0;
    p1_valid = 0; p1_write = 0; p1_address = '0; p1_wdata = '0;
    mem_ready = 0; mem_out = '0;
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_mem_valid", 128'(mem_valid), 128'(0));
    chk("rst_mem_cmd", 128'({mem_write, mem_address}), 128'(0));
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_ready", 128'({p0_ready, p1_ready}), 128'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) do_access(vecs[i]);
    chk("err_clean", 128'(err), 128'(0));

    // mem_ready outside WAIT must be ignored
    mem_ready = 1'b1;
    mem_out = '1;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("stray_ready", 128'({busy, p0_ready, p1_ready}), 128'(0));

    // Simultaneous requests, each dropped after its own service
    apply_reset();
    set_req(0, 1'b0, 32'h200, '0);
    set_req(1, 1'b0, 32'h240, '0);
    serve(0, 1'b0, 32'h200, '0, 1, 128'hA0, 128'hA0, 1'b1, n);
    serve(1, 1'b0, 32'h240, '0, 1, 128'hB1, 128'hB1, 1'b1, n);

    // Three back-to-back ties with both requests held
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_p = '{0, 1, 0};
`else
    exp_p = '{0, 0, 0};
`endif
    set_req(0, 1'b0, 32'h400, '0);
    set_req(1, 1'b0, 32'h440, '0);
    for (int i = 0; i < 3; i++) begin
      pat = 128'(i + 16'h50);
      serve(exp_p[i], 1'b0, exp_p[i] == 0 ? 32'h400 : 32'h440, '0,
            1, pat, pat, 1'b0, n);
    end
    drop_req(0);
    drop_req(1);
    tick();

    // Port 0 keeps valid across RESP->IDLE with a new address
    set_req(0, 1'b0, 32'h40, '0);
    serve(0, 1'b0, 32'h40, '0, 2, 128'h77, 128'h77, 1'b0, n);
    p0_address = 32'hC0;
    serve(0, 1'b0, 32'hC0, '0, 2, 128'h88, 128'h88, 1'b1, n);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid) cnt++;
      tick();
    end
    chk("no_duplicate_issue", 128'(cnt), 128'(0));

    // Watchdog timeout, then err stays set across a good access
    apply_reset();
    set_req(0, 1'b0, 32'h300, '0);
    wait_issue(n);
    cnt = 0;
    while (!p0_ready && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("timeout_in_window", 128'(cnt >= 17 && cnt <= 18), 128'(1));
    chk("timeout_rdata", rdata, '1);
    chk("timeout_err", 128'(err), 128'(1));
    drop_req(0);
    tick();
    do_access(vecs[1]);
    chk("err_sticky", 128'(err), 128'(1));

    // Reset while waiting on memory
    set_req(1, 1'b0, 32'h340, '0);
    wait_issue(n);
    tick();
    tick();
    reset = 1'b1;
    drop_req(1);
    tick();
    chk("rst_wait_busy", 128'(busy), 128'(0));
    chk("rst_wait_grant", 128'(grant), 128'(0));
    chk("rst_wait_err", 128'(err), 128'(0));
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (p0_ready || p1_ready) cnt++;
    end
    chk("rst_wait_no_ready", 128'(cnt), 128'(0));
    do_access(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
